// File: rtl/vga_sync_decoder.sv
// Recovers raster position from an incoming hsync/vsync pair, measures line and
// frame periods, and gates the position strobes on a lock state machine.
//   state  | meaning
//   SEARCH | counting consecutive good frames toward lock
//   LOCKED | stream proven stable, strobes and active enabled
module vga_sync_decoder #(
    parameter int H_TOTAL      = 800,
    parameter int H_ACTIVE     = 640,
    parameter int H_SYNC_START = 656,
    parameter int V_TOTAL      = 525,
    parameter int V_ACTIVE     = 480,
    parameter int V_SYNC_START = 490,
    parameter int LOCK_FRAMES  = 2
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [9:0] hpos,
    output logic [8:0] vpos,
    output logic       active,
    output logic       line_pulse,
    output logic       frame_pulse,
    output logic       locked,
    output logic [9:0] line_len,
    output logic [9:0] frame_len,
    output logic       timing_error
);

    typedef enum logic {SEARCH, LOCKED} lock_state_t;

    localparam logic [9:0] CNT_MAX = 10'd1023;

    lock_state_t state;
    logic        hs_d, hs_dd, vs_d, vs_dd;
    logic        hs_fall, vs_fall, h_wrap;
    logic [9:0]  hcnt, vcnt, lcnt, fcnt;
    logic [9:0]  line_len_nxt, frame_len_nxt;
    logic        line_armed, frame_armed, to_flag, frame_bad;
    logic        bad_line, bad_frame, timeout, good_frame, any_err;
    logic [2:0]  good_cnt;

    assign hs_fall = hs_dd & ~hs_d;
    assign vs_fall = vs_dd & ~vs_d;
    assign h_wrap  = (hcnt == 10'(H_TOTAL - 1)) & ~hs_fall;

    // An hsync fall coincident with the vsync fall still belongs to the ending frame
    assign line_len_nxt  = (lcnt == CNT_MAX) ? CNT_MAX : lcnt + 10'd1;
    assign frame_len_nxt = (hs_fall && fcnt != CNT_MAX) ? fcnt + 10'd1 : fcnt;

    assign bad_line   = hs_fall & line_armed & (line_len_nxt != 10'(H_TOTAL));
    assign timeout    = line_armed & ~hs_fall & ~to_flag & (lcnt == CNT_MAX);
    assign bad_frame  = vs_fall & frame_armed & (frame_len_nxt != 10'(V_TOTAL));
    assign good_frame = vs_fall & frame_armed & ~bad_frame & ~frame_bad & ~bad_line & ~timeout;
    assign any_err    = bad_line | bad_frame | timeout;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            hs_d        <= 1'b1;
            hs_dd       <= 1'b1;
            vs_d        <= 1'b1;
            vs_dd       <= 1'b1;
            hcnt        <= '0;
            vcnt        <= '0;
            lcnt        <= '0;
            fcnt        <= '0;
            line_len    <= '0;
            frame_len   <= '0;
            line_armed  <= 1'b0;
            frame_armed <= 1'b0;
            to_flag     <= 1'b0;
            frame_bad   <= 1'b0;
        end else begin
            hs_d  <= hsync_in;
            hs_dd <= hs_d;
            vs_d  <= vsync_in;
            vs_dd <= vs_d;

            if (hs_fall)
                hcnt <= 10'(H_SYNC_START);
            else if (hcnt == 10'(H_TOTAL - 1))
                hcnt <= '0;
            else
                hcnt <= hcnt + 10'd1;

            if (vs_fall)
                vcnt <= 10'(V_SYNC_START);
            else if (h_wrap)
                vcnt <= (vcnt == 10'(V_TOTAL - 1)) ? 10'd0 : vcnt + 10'd1;

            if (hs_fall) begin
                lcnt       <= '0;
                line_len   <= line_len_nxt;
                line_armed <= 1'b1;
                to_flag    <= 1'b0;
            end else begin
                if (lcnt != CNT_MAX)
                    lcnt <= lcnt + 10'd1;
                if (timeout)
                    to_flag <= 1'b1;
            end

            if (vs_fall) begin
                fcnt        <= '0;
                frame_len   <= frame_len_nxt;
                frame_armed <= 1'b1;
                frame_bad   <= 1'b0;
            end else begin
                fcnt <= frame_len_nxt;
                if (bad_line || timeout)
                    frame_bad <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state        <= SEARCH;
            good_cnt     <= '0;
            locked       <= 1'b0;
            timing_error <= 1'b0;
        end else begin
            timing_error <= any_err;
            case (state)
                SEARCH: begin
                    if (any_err) begin
                        good_cnt <= '0;
                    end else if (good_frame) begin
                        if (good_cnt + 3'd1 >= 3'(LOCK_FRAMES)) begin
                            state    <= LOCKED;
                            locked   <= 1'b1;
                            good_cnt <= '0;
                        end else begin
                            good_cnt <= good_cnt + 3'd1;
                        end
                    end
                end
                LOCKED: begin
                    if (any_err) begin
                        state    <= SEARCH;
                        locked   <= 1'b0;
                        good_cnt <= '0;
                    end
                end
                default: begin
                    state    <= SEARCH;
                    locked   <= 1'b0;
                    good_cnt <= '0;
                end
            endcase
        end
    end

    assign hpos        = hcnt;
    assign vpos        = vcnt[8:0];
    assign active      = locked & (hcnt < 10'(H_ACTIVE)) & (vcnt < 10'(V_ACTIVE));
    assign line_pulse  = locked & (hcnt == 10'(H_TOTAL - 1));
    assign frame_pulse = line_pulse & (vcnt == 10'(V_TOTAL - 1));

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a scaled-down 40x12 raster so that
// lock, loss and re-lock all happen within a few thousand clocks.
module tb_vga_sync_decoder;

    localparam int HT  = 40;
    localparam int HA  = 32;
    localparam int HSS = 34;
    localparam int VT  = 12;
    localparam int VA  = 9;
    localparam int VSS = 10;
    localparam int LF  = 2;

    logic       clk = 1'b0;
    logic       nRst;
    logic       hsync_in, vsync_in;
    logic [9:0] hpos;
    logic [8:0] vpos;
    logic       active, line_pulse, frame_pulse, locked;
    logic [9:0] line_len, frame_len;
    logic       timing_error;

    vga_sync_decoder #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS),
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .nRst(nRst), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hpos(hpos), .vpos(vpos), .active(active), .line_pulse(line_pulse),
        .frame_pulse(frame_pulse), .locked(locked), .line_len(line_len),
        .frame_len(frame_len), .timing_error(timing_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Source raster: hsync first reads low at sx = HSS+1, vsync falls together with it
    int sx = 0, sy = 0;
    int line_lim = HT, frame_lim = VT;
    bit short_arm = 0, long_arm = 0, hold = 0;
    int hs_since = 0, vs_since = 0, vs_count = 0, err_cnt = 0;

    task automatic step();
        logic new_hs, new_vs;
        @(posedge clk);
        #1;
        if (timing_error) err_cnt++;
        sx++;
        if (sx >= line_lim) begin
            sx = 0;
            sy++;
            if (sy >= frame_lim) begin
                sy = 0;
                frame_lim = long_arm ? VT + 1 : VT;
                long_arm = 0;
            end
            line_lim = HT;
            if (short_arm && sy == 3) begin
                line_lim = HT - 1;
                short_arm = 0;
            end
        end
        new_hs = hold ? 1'b1 : !(sx >= HSS + 1 && sx < HSS + 5);
        new_vs = hold ? 1'b1 : !((sy == VSS && sx >= HSS + 1) || (sy == VSS + 1 && sx < HSS + 1));
        if (hsync_in && !new_hs) hs_since = 0; else hs_since++;
        if (vsync_in && !new_vs) begin vs_since = 0; vs_count++; end else vs_since++;
        hsync_in = new_hs;
        vsync_in = new_vs;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({hpos, vpos, active, line_pulse, frame_pulse, locked, line_len, frame_len, timing_error} !== 44'd0)
            $display("FAIL reset_outputs: got %h want 0",
                     {hpos, vpos, active, line_pulse, frame_pulse, locked, line_len, frame_len, timing_error});
        else n_pass++;
        @(negedge clk);
        nRst = 1'b1;
    endtask

    task automatic test_lock();
        bit found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            step();
            if (locked) found = 1;
        end
        n_checks++;
        if (found !== 1'b1) $display("FAIL lock_seen: got %0d want 1", found); else n_pass++;
        n_checks++;
        if (vs_count !== 3) $display("FAIL lock_vs_count: got %0d want 3", vs_count); else n_pass++;
        n_checks++;
        if (vs_since !== 2) $display("FAIL lock_latency: got %0d want 2", vs_since); else n_pass++;
        n_checks++;
        if (line_len !== 10'(HT)) $display("FAIL lock_line_len: got %0d want %0d", line_len, HT); else n_pass++;
        n_checks++;
        if (frame_len !== 10'(VT)) $display("FAIL lock_frame_len: got %0d want %0d", frame_len, VT); else n_pass++;
        n_checks++;
        if (err_cnt !== 0) $display("FAIL lock_no_error: got %0d want 0", err_cnt); else n_pass++;
    endtask

    task automatic test_locked_stream();
        int act = 0, fp = 0, lp = 0, bad_h = 0;
        repeat (HT * VT) begin
            step();
            if (active) act++;
            if (frame_pulse) fp++;
            if (line_pulse) lp++;
            if (hpos !== 10'((sx + HT - 3) % HT)) bad_h++;
        end
        n_checks++;
        if (bad_h !== 0) $display("FAIL hpos_offset: got %0d bad samples want 0", bad_h); else n_pass++;
        n_checks++;
        if (act !== HA * VA) $display("FAIL active_count: got %0d want %0d", act, HA * VA); else n_pass++;
        n_checks++;
        if (fp !== 1) $display("FAIL frame_pulse_count: got %0d want 1", fp); else n_pass++;
        n_checks++;
        if (lp !== VT) $display("FAIL line_pulse_count: got %0d want %0d", lp, VT); else n_pass++;
    endtask

    task automatic test_short_line();
        bit got = 0, relock = 0;
        int vs_at;
        err_cnt = 0;
        short_arm = 1;
        for (int i = 0; i < 2000 && !got; i++) begin
            step();
            if (timing_error) got = 1;
        end
        n_checks++;
        if (got !== 1'b1) $display("FAIL short_error_seen: got %0d want 1", got); else n_pass++;
        n_checks++;
        if (line_len !== 10'(HT - 1)) $display("FAIL short_line_len: got %0d want %0d", line_len, HT - 1); else n_pass++;
        n_checks++;
        if (locked !== 1'b0) $display("FAIL short_unlock: got %0d want 0", locked); else n_pass++;
        vs_at = vs_count;
        for (int i = 0; i < 3000 && !relock; i++) begin
            step();
            if (locked) relock = 1;
        end
        n_checks++;
        if (vs_count - vs_at !== 3) $display("FAIL short_relock_frames: got %0d want 3", vs_count - vs_at); else n_pass++;
        n_checks++;
        if (vs_since !== 2) $display("FAIL short_relock_latency: got %0d want 2", vs_since); else n_pass++;
        n_checks++;
        if (err_cnt !== 1) $display("FAIL short_error_count: got %0d want 1", err_cnt); else n_pass++;
    endtask

    task automatic test_hsync_hold();
        int first_since = -1;
        bit fell = 0, relock = 0;
        err_cnt = 0;
        hold = 1;
        repeat (2000) begin
            step();
            if (timing_error && first_since < 0) first_since = hs_since;
        end
        n_checks++;
        if (err_cnt !== 1) $display("FAIL hold_error_count: got %0d want 1", err_cnt); else n_pass++;
        n_checks++;
        if (first_since !== 1026) $display("FAIL hold_error_time: got %0d want 1026", first_since); else n_pass++;
        n_checks++;
        if (locked !== 1'b0) $display("FAIL hold_unlock: got %0d want 0", locked); else n_pass++;
        hold = 0;
        for (int i = 0; i < 200 && !fell; i++) begin
            step();
            if (hs_since == 2) fell = 1;
        end
        n_checks++;
        if (line_len !== 10'd1023) $display("FAIL hold_line_len: got %0d want 1023", line_len); else n_pass++;
        for (int i = 0; i < 5000 && !relock; i++) begin
            step();
            if (locked) relock = 1;
        end
        n_checks++;
        if (relock !== 1'b1) $display("FAIL hold_relock: got %0d want 1", relock); else n_pass++;
    endtask

    task automatic test_long_frame();
        bit got = 0, relock = 0;
        int vs_at;
        err_cnt = 0;
        long_arm = 1;
        for (int i = 0; i < 2000 && !got; i++) begin
            step();
            if (timing_error) got = 1;
        end
        n_checks++;
        if (frame_len !== 10'(VT + 1)) $display("FAIL long_frame_len: got %0d want %0d", frame_len, VT + 1); else n_pass++;
        n_checks++;
        if (locked !== 1'b0) $display("FAIL long_unlock: got %0d want 0", locked); else n_pass++;
        vs_at = vs_count;
        for (int i = 0; i < 3000 && !relock; i++) begin
            step();
            if (locked) relock = 1;
        end
        n_checks++;
        if (vs_count - vs_at !== 2) $display("FAIL long_relock_frames: got %0d want 2", vs_count - vs_at); else n_pass++;
        n_checks++;
        if (err_cnt !== 1) $display("FAIL long_error_count: got %0d want 1", err_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid_line();
        bit mid = 0;
        for (int i = 0; i < 100 && !mid; i++) begin
            step();
            if (sx == 10) mid = 1;
        end
        n_checks++;
        if (locked !== 1'b1) $display("FAIL pre_reset_locked: got %0d want 1", locked); else n_pass++;
        @(posedge clk);
        #3;
        nRst = 1'b0;
        #1;
        n_checks++;
        if ({hpos, vpos, active, line_pulse, frame_pulse, locked, line_len, frame_len, timing_error} !== 44'd0)
            $display("FAIL async_reset_outputs: got %h want 0",
                     {hpos, vpos, active, line_pulse, frame_pulse, locked, line_len, frame_len, timing_error});
        else n_pass++;
        hold = 1;
        repeat (2) step();
        @(negedge clk);
        nRst = 1'b1;
        err_cnt = 0;
        repeat (5) step();
        n_checks++;
        if (hpos !== 10'd5) $display("FAIL release_hpos: got %0d want 5", hpos); else n_pass++;
        n_checks++;
        if ({line_len, frame_len, locked} !== 21'd0 || err_cnt !== 0)
            $display("FAIL release_quiet: got line_len=%0d frame_len=%0d locked=%0d errors=%0d want all 0",
                     line_len, frame_len, locked, err_cnt);
        else n_pass++;
    endtask

    initial begin
        nRst     = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        test_reset();
        test_lock();
        test_locked_stream();
        test_short_line();
        test_hsync_hold();
        test_long_frame();
        test_reset_mid_line();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
